// File: rtl/dioptase_alu.sv
// Dioptase execute-stage integer ALU: zero-latency 32-bit result and the
// architectural C/Z/S/O flags register consumed by branch resolution.
module dioptase_alu (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  opcode_i,
    input  logic [4:0]  alu_op_i,
    input  logic [31:0] lhs_i,
    input  logic [31:0] rhs_i,
    input  logic        bubble_in_i,
    input  logic [31:0] flags_restore_i,
    input  logic        rfe_in_wb_i,
    output logic [31:0] result_o,
    output logic [3:0]  flags_o
);

    localparam logic [4:0] OPC_ALU_A = 5'd0;
    localparam logic [4:0] OPC_ALU_B = 5'd1;
    localparam logic [4:0] OPC_LUI   = 5'd2;

    localparam logic [4:0] OP_AND  = 5'd0;
    localparam logic [4:0] OP_NAND = 5'd1;
    localparam logic [4:0] OP_OR   = 5'd2;
    localparam logic [4:0] OP_NOR  = 5'd3;
    localparam logic [4:0] OP_XOR  = 5'd4;
    localparam logic [4:0] OP_XNOR = 5'd5;
    localparam logic [4:0] OP_NOT  = 5'd6;
    localparam logic [4:0] OP_LSL  = 5'd7;
    localparam logic [4:0] OP_LSR  = 5'd8;
    localparam logic [4:0] OP_ASR  = 5'd9;
    localparam logic [4:0] OP_ROTL = 5'd10;
    localparam logic [4:0] OP_ROTR = 5'd11;
    localparam logic [4:0] OP_LSLC = 5'd12;
    localparam logic [4:0] OP_LSRC = 5'd13;
    localparam logic [4:0] OP_ADD  = 5'd14;
    localparam logic [4:0] OP_ADDC = 5'd15;
    localparam logic [4:0] OP_SUB  = 5'd16;
    localparam logic [4:0] OP_SUBB = 5'd17;
    localparam logic [4:0] OP_MUL  = 5'd18;

    // Returns {carry_out, signed_overflow, sum[31:0]} of a + b + cin.
    function automatic logic [33:0] add_flags(input logic [31:0] a,
                                              input logic [31:0] b,
                                              input logic        cin);
        logic [32:0] sum;
        logic        ovf;
        sum = {1'b0, a} + {1'b0, b} + {32'd0, cin};
        ovf = (a[31] == b[31]) && (sum[31] != a[31]);
        return {sum[32], ovf, sum[31:0]};
    endfunction

    logic [3:0]  flags_q;
    logic [3:0]  flags_d;
    logic        carry_q_s;
    logic [4:0]  amt_s;
    logic        amt_zero_s;
    logic [5:0]  amt_inv_s;

    logic [32:0] lsl_ext_s;
    logic [32:0] lsr_ext_s;
    logic [32:0] asr_ext_s;
    logic [31:0] rotl_s;
    logic [31:0] rotr_s;
    logic [31:0] fill_lo_s;
    logic [31:0] fill_hi_s;
    logic [31:0] mul_s;
    logic [31:0] addr_sum_s;

    logic        is_sub_s;
    logic [31:0] add_b_s;
    logic        add_cin_s;
    logic [33:0] add_out_s;

    logic [31:0] alu_res_s;
    logic        alu_c_s;
    logic        alu_o_s;
    logic [3:0]  next_flags_s;
    logic        is_alu_s;
    logic [31:0] result_s;
    logic        unused_restore_s;

    assign carry_q_s  = flags_q[0];
    assign amt_s      = rhs_i[4:0];
    assign amt_zero_s = (amt_s == 5'd0);
    assign amt_inv_s  = 6'd32 - {1'b0, amt_s};

    // Extra bit on the far side of each shift catches the last bit shifted out.
    assign lsl_ext_s  = {1'b0, lhs_i} << amt_s;
    assign lsr_ext_s  = {lhs_i, 1'b0} >> amt_s;
    assign asr_ext_s  = 33'($signed({lhs_i, 1'b0}) >>> amt_s);
    assign rotl_s     = (lhs_i << amt_s) | (lhs_i >> amt_inv_s);
    assign rotr_s     = (lhs_i >> amt_s) | (lhs_i << amt_inv_s);
    assign fill_lo_s  = (32'd1 << amt_s) - 32'd1;
    assign fill_hi_s  = ~(32'hFFFF_FFFF >> amt_s);
    assign mul_s      = lhs_i * rhs_i;
    assign addr_sum_s = lhs_i + rhs_i;

    assign is_sub_s   = (alu_op_i == OP_SUB) || (alu_op_i == OP_SUBB);
    assign add_b_s    = is_sub_s ? ~rhs_i : rhs_i;
    assign add_out_s  = add_flags(lhs_i, add_b_s, add_cin_s);

    assign unused_restore_s = ^flags_restore_i[31:4];

    // Carry-in selection for the shared add/subtract adder.
    always_comb begin
        add_cin_s = 1'b0;
        case (alu_op_i)
            OP_ADD:  add_cin_s = 1'b0;
            OP_ADDC: add_cin_s = carry_q_s;
            OP_SUB:  add_cin_s = 1'b1;
            OP_SUBB: add_cin_s = carry_q_s;
            default: add_cin_s = 1'b0;
        endcase
    end

    // ALU operation result with its carry and overflow contributions.
    always_comb begin
        alu_res_s = 32'd0;
        alu_c_s   = 1'b0;
        alu_o_s   = 1'b0;
        case (alu_op_i)
            OP_AND:  alu_res_s = lhs_i & rhs_i;
            OP_NAND: alu_res_s = ~(lhs_i & rhs_i);
            OP_OR:   alu_res_s = lhs_i | rhs_i;
            OP_NOR:  alu_res_s = ~(lhs_i | rhs_i);
            OP_XOR:  alu_res_s = lhs_i ^ rhs_i;
            OP_XNOR: alu_res_s = ~(lhs_i ^ rhs_i);
            OP_NOT:  alu_res_s = ~rhs_i;
            OP_LSL: begin
                alu_res_s = lsl_ext_s[31:0];
                alu_c_s   = lsl_ext_s[32];
            end
            OP_LSR: begin
                alu_res_s = lsr_ext_s[32:1];
                alu_c_s   = lsr_ext_s[0];
            end
            OP_ASR: begin
                alu_res_s = asr_ext_s[32:1];
                alu_c_s   = asr_ext_s[0];
            end
            OP_ROTL: begin
                alu_res_s = rotl_s;
                alu_c_s   = amt_zero_s ? 1'b0 : rotl_s[0];
            end
            OP_ROTR: begin
                alu_res_s = rotr_s;
                alu_c_s   = amt_zero_s ? 1'b0 : rotr_s[31];
            end
            OP_LSLC: begin
                alu_res_s = lsl_ext_s[31:0] | (carry_q_s ? fill_lo_s : 32'd0);
                alu_c_s   = lsl_ext_s[32];
            end
            OP_LSRC: begin
                alu_res_s = lsr_ext_s[32:1] | (carry_q_s ? fill_hi_s : 32'd0);
                alu_c_s   = lsr_ext_s[0];
            end
            OP_ADD, OP_ADDC, OP_SUB, OP_SUBB: begin
                alu_res_s = add_out_s[31:0];
                alu_c_s   = add_out_s[33];
                alu_o_s   = add_out_s[32];
            end
            OP_MUL:  alu_res_s = mul_s;
            default: alu_res_s = 32'd0;
        endcase
    end

    assign next_flags_s = {alu_o_s, alu_res_s[31], (alu_res_s == 32'd0), alu_c_s};
    assign is_alu_s     = (opcode_i == OPC_ALU_A) || (opcode_i == OPC_ALU_B);

    // Opcode-level result select; non-ALU opcodes use the address adder.
    always_comb begin
        result_s = addr_sum_s;
        case (opcode_i)
            OPC_ALU_A, OPC_ALU_B: result_s = alu_res_s;
            OPC_LUI:              result_s = rhs_i;
            default:              result_s = addr_sum_s;
        endcase
    end

    // Flags next state: rfe restore beats a live flag-setting instruction.
    always_comb begin
        flags_d = flags_q;
        if (rfe_in_wb_i) begin
            flags_d = flags_restore_i[3:0];
        end else if (!bubble_in_i && is_alu_s) begin
            flags_d = next_flags_s;
        end else begin
            flags_d = flags_q;
        end
    end

    // Architectural flags register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            flags_q <= 4'b0000;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign result_o = result_s;
    assign flags_o  = flags_q;

endmodule

// File: tb/tb_dioptase_alu.sv
// Self-checking bench for dioptase_alu: directed cases followed by random
// steps compared against an arithmetic reference model of the ALU and flags.
module tb_dioptase_alu;

    logic        clk;
    logic        rst;
    logic [4:0]  opcode;
    logic [4:0]  alu_op;
    logic [31:0] lhs;
    logic [31:0] rhs;
    logic        bubble_in;
    logic [31:0] flags_restore;
    logic        rfe_in_wb;
    logic [31:0] result;
    logic [3:0]  flags;

    int          checks;
    int          errors;
    logic [3:0]  exp_flags;
    logic [31:0] obs_res;
    logic [3:0]  obs_flags;

    dioptase_alu dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .opcode_i        (opcode),
        .alu_op_i        (alu_op),
        .lhs_i           (lhs),
        .rhs_i           (rhs),
        .bubble_in_i     (bubble_in),
        .flags_restore_i (flags_restore),
        .rfe_in_wb_i     (rfe_in_wb),
        .result_o        (result),
        .flags_o         (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: result and next flags from the architectural rules.
    function automatic void model(input logic [4:0] op, input logic [4:0] aop,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input logic [3:0] f,
                                  output logic [31:0] res, output logic [3:0] nf);
        logic [31:0] v;
        logic        c;
        logic        o;
        logic        fill;
        longint      s;
        logic [63:0] u;
        int          n;
        c = 1'b0;
        o = 1'b0;
        res = 32'd0;
        n = int'(b[4:0]);
        if (op == 5'd2) begin
            res = b;
        end else if (op > 5'd2) begin
            u = {32'd0, a} + {32'd0, b};
            res = u[31:0];
        end else begin
            if (aop <= 5'd6) begin
                case (aop)
                    5'd0: res = a & b;
                    5'd1: res = ~(a & b);
                    5'd2: res = a | b;
                    5'd3: res = ~(a | b);
                    5'd4: res = a ^ b;
                    5'd5: res = ~(a ^ b);
                    default: res = ~b;
                endcase
            end else if (aop <= 5'd13) begin
                v = a;
                for (int i = 0; i < n; i++) begin
                    if (aop == 5'd7 || aop == 5'd10 || aop == 5'd12) begin
                        fill = (aop == 5'd7) ? 1'b0 : (aop == 5'd10) ? v[31] : f[0];
                        c = v[31];
                        v = {v[30:0], fill};
                    end else begin
                        fill = (aop == 5'd8) ? 1'b0 : (aop == 5'd9) ? v[31] :
                               (aop == 5'd11) ? v[0] : f[0];
                        c = v[0];
                        v = {fill, v[31:1]};
                    end
                end
                res = v;
            end else if (aop <= 5'd15) begin
                u = {32'd0, a} + {32'd0, b} + ((aop == 5'd15) ? {63'd0, f[0]} : 64'd0);
                s = longint'($signed(a)) + longint'($signed(b)) + ((aop == 5'd15) ? longint'(f[0]) : 64'sd0);
                res = u[31:0];
                c = u[32];
                o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end else if (aop <= 5'd17) begin
                fill = (aop == 5'd16) ? 1'b1 : f[0];
                u = {32'd0, a} + (64'hFFFF_FFFF - {32'd0, b}) + {63'd0, fill};
                s = longint'($signed(a)) - longint'($signed(b)) - 64'sd1 + longint'(fill);
                res = u[31:0];
                c = u[32];
                o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end else if (aop == 5'd18) begin
                u = {32'd0, a} * {32'd0, b};
                res = u[31:0];
            end else begin
                res = 32'd0;
            end
        end
        nf = {o, res[31], (res == 32'd0), c};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One instruction: check result before the edge, flags after it.
    task automatic apply(input logic r, input logic [4:0] op, input logic [4:0] aop,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic bub, input logic rfe, input logic [31:0] restore);
        logic [31:0] m_res;
        logic [3:0]  m_nf;
        rst = r; opcode = op; alu_op = aop; lhs = a; rhs = b;
        bubble_in = bub; rfe_in_wb = rfe; flags_restore = restore;
        #1;
        model(op, aop, a, b, exp_flags, m_res, m_nf);
        obs_res = result;
        chk("result_model", obs_res, m_res);
        @(posedge clk);
        #1;
        if (r) exp_flags = 4'b0000;
        else if (rfe) exp_flags = restore[3:0];
        else if (!bub && op < 5'd2) exp_flags = m_nf;
        else exp_flags = exp_flags;
        obs_flags = flags;
        chk("flags_model", {28'd0, obs_flags}, {28'd0, exp_flags});
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [4:0]  rop;
        checks = 0;
        errors = 0;
        exp_flags = 4'b0000;
        rst = 1'b0; opcode = 5'd3; alu_op = 5'd0; lhs = 32'd0; rhs = 32'd0;
        bubble_in = 1'b0; rfe_in_wb = 1'b0; flags_restore = 32'd0;
        @(negedge clk);

        apply(1'b1, 5'd3, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("reset_flags", {28'd0, obs_flags}, 32'h0);
        apply(1'b0, 5'd0, 5'd14, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0);
        chk("add_wrap_res", obs_res, 32'h0);
        chk("add_wrap_flags", {28'd0, obs_flags}, 32'h3);
        apply(1'b0, 5'd1, 5'd16, 32'h5, 32'h7, 1'b0, 1'b0, 32'h0);
        chk("sub_neg_res", obs_res, 32'hFFFF_FFFE);
        chk("sub_neg_flags", {28'd0, obs_flags}, 32'h4);
        apply(1'b0, 5'd1, 5'd16, 32'h8000_0000, 32'h1, 1'b0, 1'b0, 32'h0);
        chk("sub_ovf_res", obs_res, 32'h7FFF_FFFF);
        chk("sub_ovf_flags", {28'd0, obs_flags}, 32'h9);
        apply(1'b0, 5'd0, 5'd15, 32'h2, 32'h3, 1'b1, 1'b0, 32'h0);
        chk("addc_res", obs_res, 32'h6);
        apply(1'b0, 5'd0, 5'd12, 32'h1, 32'h4, 1'b1, 1'b0, 32'h0);
        chk("lslc_res", obs_res, 32'h1F);
        apply(1'b0, 5'd0, 5'd9, 32'h8000_0000, 32'd31, 1'b1, 1'b0, 32'h0);
        chk("asr31_res", obs_res, 32'hFFFF_FFFF);
        chk("bubble_hold_flags", {28'd0, obs_flags}, 32'h9);
        apply(1'b0, 5'd3, 5'd14, 32'h1000, 32'h10, 1'b0, 1'b0, 32'h0);
        chk("mem_addr_res", obs_res, 32'h1010);
        chk("mem_addr_flags", {28'd0, obs_flags}, 32'h9);
        apply(1'b0, 5'd2, 5'd0, 32'h1234_5678, 32'hABCD_0000, 1'b0, 1'b0, 32'h0);
        chk("lui_res", obs_res, 32'hABCD_0000);
        chk("lui_flags", {28'd0, obs_flags}, 32'h9);
        apply(1'b0, 5'd0, 5'd14, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("bubble_add_flags", {28'd0, obs_flags}, 32'h9);
        apply(1'b0, 5'd0, 5'd14, 32'h1, 32'h1, 1'b0, 1'b1, 32'h0000_000A);
        chk("rfe_res", obs_res, 32'h2);
        chk("rfe_flags", {28'd0, obs_flags}, 32'hA);
        apply(1'b0, 5'd0, 5'd18, 32'h0001_0000, 32'h0001_0001, 1'b0, 1'b0, 32'h0);
        chk("mul_res", obs_res, 32'h0001_0000);
        chk("mul_flags", {28'd0, obs_flags}, 32'h0);
        apply(1'b0, 5'd0, 5'd10, 32'h8000_0001, 32'h1, 1'b0, 1'b0, 32'h0);
        chk("rotl_res", obs_res, 32'h3);
        chk("rotl_flags", {28'd0, obs_flags}, 32'h1);
        apply(1'b0, 5'd0, 5'd13, 32'h8000_0000, 32'h4, 1'b0, 1'b0, 32'h0);
        chk("lsrc_res", obs_res, 32'hF800_0000);
        chk("lsrc_flags", {28'd0, obs_flags}, 32'h4);
        apply(1'b0, 5'd0, 5'd8, 32'h0000_DEAD, 32'd32, 1'b0, 1'b0, 32'h0);
        chk("shift0_res", obs_res, 32'h0000_DEAD);
        chk("shift0_flags", {28'd0, obs_flags}, 32'h0);
        apply(1'b0, 5'd1, 5'd25, 32'h1234_5678, 32'h9, 1'b0, 1'b0, 32'h0);
        chk("reserved_res", obs_res, 32'h0);
        chk("reserved_flags", {28'd0, obs_flags}, 32'h2);
        apply(1'b1, 5'd0, 5'd14, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1, 32'hF);
        chk("rst_mid_res", obs_res, 32'h8000_0000);
        chk("rst_mid_flags", {28'd0, obs_flags}, 32'h0);

        for (int i = 0; i < 400; i++) begin
            ra = $urandom();
            rb = $urandom();
            case ($urandom_range(0, 5))
                0: ra = 32'h8000_0000;
                1: rb = 32'hFFFF_FFFF;
                2: rb = ra;
                default: ra = ra;
            endcase
            rop = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(2, 31)) : 5'($urandom_range(0, 1));
            apply(($urandom_range(0, 31) == 0), rop, 5'($urandom_range(0, 31)), ra, rb,
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0), $urandom());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dioptase_alu.md
Name: dioptase_alu

Overview:
- Integer ALU of the Dioptase execute stage: combinational 32-bit result plus an architectural 4-bit flags register (C, Z, S, O).
- Branch logic reads the flags in the execute stage.
- Execute computes operands, including the immediate and subtract-immediate operand swap, before they reach this block.

Parameters:
- None (fixed 32-bit datapath).

Ports:
- clk  in  1  clock, flags register updates on rising edge
- rst  in  1  synchronous active-high reset
- opcode  in  5  instruction opcode
- alu_op  in  5  ALU operation select (used when opcode is 0 or 1)
- lhs  in  32  left operand
- rhs  in  32  right operand (shift amount in rhs[4:0])
- bubble_in  in  1  instruction in execute is a bubble
- flags_restore  in  32  saved flags; bits [3:0] restored on rfe
- rfe_in_wb  in  1  return-from-exception in writeback: restore flags
- result  out  32  combinational result
- flags  out  4  registered flags: [0]=C, [1]=Z, [2]=S, [3]=O

Behaviour:
- Result by opcode:
  - opcode 0 or 1: per alu_op table below.
  - opcode 2 (lui): result = rhs.
  - All other opcodes (memory address, branch, priv): result = lhs + rhs, mod 2^32.
- alu_op table (opcode 0/1):
  - 0 and; 1 nand; 2 or; 3 nor; 4 xor; 5 xnor; 6 not (~rhs).
  - 7 lsl; 8 lsr; 9 asr; 10 rotl; 11 rotr.
  - 12 lslc (lsl, vacated bits filled with flags C); 13 lsrc (lsr, vacated bits filled with flags C).
  - 14 add; 15 addc (lhs+rhs+C); 16 sub (lhs-rhs); 17 subb (lhs+~rhs+C).
  - 18 mul (low 32 bits of product).
  - 19–31: result 0.
- Shift amount is rhs[4:0]; amount 0 returns lhs unchanged.
- Next-flag computation (combinational, from the current operation):
  - Z = (result == 0); S = result[31].
  - add/addc: C = carry out of bit 31; O = signed overflow.
  - sub/subb: computed as lhs + ~rhs + cin, with cin = 1 for sub and cin = C for subb. C = carry out, i.e. 1 means no borrow (lhs >= rhs unsigned for sub). O = signed overflow.
  - Shifts/rotates: C = last bit shifted or rotated out (0 if amount 0); O = 0.
  - Logic, mul, reserved ops: C = 0, O = 0.
- Flags register update on posedge clk, in priority order:
  1. rst: flags <= 4'b0000.
  2. rfe_in_wb: flags <= flags_restore[3:0]. Applies regardless of bubble_in or opcode.
  3. !bubble_in and opcode is 0 or 1: flags <= next flags.
  4. Otherwise hold.
- Flags semantics:
  - flags output is the register only, never the next value. An instruction sees the flags of the previous flag-setting instruction.
  - Opcodes 2–31 (lui, memory, branches) never modify flags.
- result has zero latency, with no dependence on rst or bubble_in.
- Reset mid-stream: flags clear on that edge; result unaffected.

Test Plan:
- rst=1 for one edge -> flags=0000. Then opcode=0, alu_op=14, lhs=0xFFFFFFFF, rhs=1 -> result=0; after edge flags C=1, Z=1, S=0, O=0 (0011).
- opcode=1, alu_op=16, lhs=5, rhs=7 -> result=0xFFFFFFFE; after edge C=0, Z=0, S=1, O=0 (0100). Repeat with lhs=0x80000000, rhs=1 -> result=0x7FFFFFFF; C=1, O=1 (1001).
- With C=1: alu_op=15, lhs=2, rhs=3 -> result=6. alu_op=12, lhs=1, rhs=4 -> result=0x1F; alu_op=9, lhs=0x80000000, rhs=31 -> result=0xFFFFFFFF.
- opcode=3, lhs=0x1000, rhs=0x10 -> result=0x1010, flags unchanged after edge. opcode=2, rhs=0xABCD0000 -> result=0xABCD0000, flags unchanged.
- bubble_in=1 with opcode=0 add producing zero -> flags unchanged.
- rfe_in_wb=1, flags_restore=0x0000000A, simultaneous valid add -> flags=1010.
- alu_op=18, lhs=0x10000, rhs=0x10001 -> result=0x00010000, C=0, O=0. alu_op=10, lhs=0x80000001, rhs=1 -> result=0x00000003, C=1.
